spi_host_master: RTL

//  Host-side SPI controller that drives the on-chip 24-bit register SPI target over o_sck/o_copi/i_cipo/o_cs.

---
 rtl/spi_host_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_host_master.sv
// rtl/spi_host_master.sv - SPI host for the 24-bit register target (cmd/addr/data frames, LSB-first).
// Optional `SPI_READ_PIPE_EN: a read's fetch frame carries the next pending request.
module spi_host_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_ack,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_sck,
  output logic       o_copi,
  input  logic       i_cipo,
  output logic       o_cs
);

`ifdef SPI_READ_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 2) ? $clog2(CS_GAP - 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  // The IDLE cycle that acks is the last cs-high cycle, so GAP itself holds CS_GAP-1 cycles.
  localparam logic [GW-1:0] GAP_LAST = GW'((CS_GAP > 1) ? CS_GAP - 2 : 0);
  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RD = 8'h01;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [4:0]    bit_q;
  logic [GW-1:0] gap_q;
  logic [23:0]   sh_q;
  logic [7:0]    cap_q;
  logic          rd_q;
  logic          fetch_q;
  logic          prev_rd_q;
  logic          ack_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    rdata_q;
  logic          sck_q;
  logic          copi_q;
  logic          cs_q;

  logic          div_end;
  logic [23:0]   new_frame;

  assign div_end   = (div_q == DIV_LAST);
  assign new_frame = i_we ? {i_wdata, i_addr, CMD_WR} : {8'h00, i_addr, CMD_RD};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      sh_q      <= '0;
      cap_q     <= '0;
      rd_q      <= 1'b0;
      fetch_q   <= 1'b0;
      prev_rd_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      sck_q     <= 1'b0;
      copi_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_req) begin
            ack_q     <= 1'b1;
            busy_q    <= 1'b1;
            cs_q      <= 1'b0;
            sck_q     <= 1'b0;
            copi_q    <= new_frame[0];
            sh_q      <= {1'b0, new_frame[23:1]};
            rd_q      <= ~i_we;
            fetch_q   <= 1'b0;
            prev_rd_q <= 1'b0;
            div_q     <= '0;
            bit_q     <= '0;
            state_q   <= SETUP;
          end
        end
        SETUP, SHIFT_LO: begin
          div_q <= div_q + 1'b1;
          if (div_end) begin
            div_q   <= '0;
            sck_q   <= 1'b1;
            // Shifting right leaves the last eight captured bits LSB-first in cap_q.
            cap_q   <= {i_cipo, cap_q[7:1]};
            state_q <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          div_q <= div_q + 1'b1;
          if (div_end) begin
            div_q <= '0;
            sck_q <= 1'b0;
            if (bit_q != 5'd23) begin
              bit_q   <= bit_q + 5'd1;
              copi_q  <= sh_q[0];
              sh_q    <= {1'b0, sh_q[23:1]};
              state_q <= SHIFT_LO;
            end else begin
              bit_q <= '0;
              if (prev_rd_q) begin
                rdata_q   <= cap_q;
                done_q    <= 1'b1;
                prev_rd_q <= 1'b0;
              end
              if (rd_q && !fetch_q) begin
                state_q <= SHIFT_LO;
                if (PIPE_EN && i_req) begin
                  ack_q     <= 1'b1;
                  copi_q    <= new_frame[0];
                  sh_q      <= {1'b0, new_frame[23:1]};
                  rd_q      <= ~i_we;
                  fetch_q   <= 1'b0;
                  prev_rd_q <= 1'b1;
                end else begin
                  copi_q  <= 1'b0;
                  sh_q    <= '0;
                  fetch_q <= 1'b1;
                end
              end else begin
                state_q <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          div_q <= div_q + 1'b1;
          if (div_end) begin
            div_q   <= '0;
            cs_q    <= 1'b1;
            copi_q  <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            gap_q   <= '0;
            if (rd_q) rdata_q <= cap_q;
            state_q <= (CS_GAP > 1) ? GAP : IDLE;
          end
        end
        GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GAP_LAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ack   = ack_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_rdata = rdata_q;
  assign o_sck   = sck_q;
  assign o_copi  = copi_q;
  assign o_cs    = cs_q;

endmodule
